// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// uart_tx_fifo : circular byte queue feeding a UART transmitter, one-cycle
//                launch pulse, busy-flag handshake with a bounded wait.
// Revision     : 1.0
// ============================================================================
module uart_tx_fifo #(
    parameter int DATA_W       = 8,
    parameter int DEPTH        = 4,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_W-1:0]        byte_in,
    input  logic                     wr_en,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [DATA_W-1:0]        byte_out,
    output logic                     tx_enable,
    input  logic                     tx_busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_LAUNCH    = 2'd1;
    localparam logic [1:0] S_WAIT_BUSY = 2'd2;
    localparam logic [1:0] S_WAIT_DONE = 2'd3;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q, count_d;
    logic              full_q, empty_q, overflow_q;
    logic [DATA_W-1:0] byte_out_q;
    logic              tx_enable_q, tx_enable_d;
    logic [1:0]        state_q, state_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              w_wr, w_pop;

    // Fullness and emptiness are judged on the registered flags, before this cycle's moves.
    assign w_wr  = wr_en && !full_q;
    assign w_pop = (state_q == S_IDLE) && !empty_q && !tx_busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        case (state_q)
            S_IDLE: begin
                if (w_pop) state_d = S_LAUNCH;
            end
            S_LAUNCH: begin
                tmo_d   = '0;
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = S_WAIT_DONE;
                end else if (tmo_q == TW'(BUSY_TIMEOUT - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        tx_enable_d = (state_d == S_LAUNCH);
    end

    always_comb begin
        count_d = count_q;
        case ({w_wr, w_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            overflow_q  <= 1'b0;
            byte_out_q  <= '0;
            tx_enable_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            full_q      <= (count_d == CW'(DEPTH));
            empty_q     <= (count_d == '0);
            tx_enable_q <= tx_enable_d;
            if (w_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (wr_en && full_q) overflow_q <= 1'b1;
            if (w_pop) begin
                byte_out_q <= mem_q[rd_ptr_q];
                rd_ptr_q   <= rd_ptr_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) mem_q[wr_ptr_q] <= byte_in;
    end

    assign full      = full_q;
    assign empty     = empty_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign byte_out  = byte_out_q;
    assign tx_enable = tx_enable_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// tb_uart_tx_fifo : directed bench for uart_tx_fifo with a simple transmitter model.
// Revision        : 1.0
// ============================================================================
module tb_uart_tx_fifo;

    localparam int C_MODEL  = 0;
    localparam int C_MANUAL = 1;
    localparam int C_IGNORE = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] byte_in = '0;
    logic       wr_en = 1'b0;
    logic       full, empty, overflow, tx_enable;
    logic [2:0] count;
    logic [7:0] byte_out;
    logic       tx_busy;

    int         mode = C_MANUAL;
    logic       man_busy = 1'b0;
    logic       model_busy = 1'b0;
    int         busy_len = 10;
    int         bcnt = 0;
    int         pulses = 0;
    logic [7:0] sent [$];

    int         n_vec = 0;
    int         n_err = 0;
    int         p0, l0;

    uart_tx_fifo #(.DATA_W(8), .DEPTH(4), .BUSY_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .byte_in(byte_in), .wr_en(wr_en),
        .full(full), .empty(empty), .count(count), .overflow(overflow),
        .byte_out(byte_out), .tx_enable(tx_enable), .tx_busy(tx_busy)
    );

    always #5 clk = ~clk;

    assign tx_busy = (mode == C_MANUAL) ? man_busy :
                     (mode == C_MODEL)  ? model_busy : 1'b0;

    // Transmitter model and launch log, both on the falling edge.
    always @(negedge clk) begin
        if (tx_enable) begin
            pulses = pulses + 1;
            sent.push_back(byte_out);
        end
        if (mode == C_MODEL) begin
            if (tx_enable) begin
                model_busy = 1'b1;
                bcnt       = busy_len;
            end else if (bcnt > 0) begin
                bcnt = bcnt - 1;
                if (bcnt == 0) model_busy = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wr(input logic [7:0] b);
        byte_in = b;
        wr_en   = 1'b1;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
    endtask

    initial begin
        // Reset values
        step();
        do_reset();
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_txen", tx_enable, 0);
        chk("rst_bout", byte_out, 0);

        // 1: single byte, busy for 10 cycles
        mode = C_MODEL; busy_len = 10; p0 = pulses; l0 = sent.size();
        wr(8'hA5);
        chk("t1_empty_after_wr", empty, 0);
        chk("t1_txen_early", tx_enable, 0);
        step();
        chk("t1_txen", tx_enable, 1);
        chk("t1_bout", byte_out, 8'hA5);
        chk("t1_empty_after_pop", empty, 1);
        step();
        chk("t1_txen_drop", tx_enable, 0);
        step(20);
        chk("t1_pulses", pulses - p0, 1);

        // 2: burst to full, overflow, in-order drain
        mode = C_MANUAL; man_busy = 1'b1; p0 = pulses; l0 = sent.size();
        for (int i = 1; i <= 4; i++) wr(8'(i));
        chk("t2_count", count, 4);
        chk("t2_full", full, 1);
        wr(8'h05);
        chk("t2_ovf", overflow, 1);
        chk("t2_count_hold", count, 4);
        busy_len = 3; mode = C_MODEL;
        step(40);
        chk("t2_pulses", pulses - p0, 4);
        for (int i = 0; i < 4; i++)
            if (l0 + i < sent.size()) chk($sformatf("t2_order%0d", i), sent[l0 + i], i + 1);
        chk("t2_empty", empty, 1);

        // 3: launch held off while busy
        do_reset();
        mode = C_MANUAL; man_busy = 1'b1; p0 = pulses;
        wr(8'h3C);
        step(5);
        chk("t3_no_pulse", pulses - p0, 0);
        chk("t3_txen_busy", tx_enable, 0);
        man_busy = 1'b0;
        step();
        chk("t3_txen", tx_enable, 1);
        chk("t3_bout", byte_out, 8'h3C);
        step(10);

        // 4: transmitter ignores the launch, wait times out
        do_reset();
        mode = C_IGNORE; p0 = pulses; l0 = sent.size();
        wr(8'h11);
        wr(8'h22);
        chk("t4_txen1", tx_enable, 1);
        chk("t4_bout1", byte_out, 8'h11);
        chk("t4_count", count, 1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("t4_wait%0d", i), tx_enable, 0);
        end
        step();
        chk("t4_txen2", tx_enable, 1);
        chk("t4_bout2", byte_out, 8'h22);
        step(15);
        chk("t4_pulses", pulses - p0, 2);

        // 5: write while full on the pop edge
        do_reset();
        mode = C_MANUAL; man_busy = 1'b1; p0 = pulses; l0 = sent.size();
        for (int i = 0; i < 4; i++) wr(8'hA1 + 8'(i));
        chk("t5_full", full, 1);
        man_busy = 1'b0;
        wr(8'h55);
        chk("t5_count", count, 3);
        chk("t5_ovf", overflow, 1);
        chk("t5_full_after", full, 0);
        chk("t5_bout", byte_out, 8'hA1);
        step(40);
        chk("t5_pulses", pulses - p0, 4);
        if (l0 + 3 < sent.size()) chk("t5_last", sent[l0 + 3], 8'hA4);

        // 6: asynchronous reset during WAIT_DONE, overflow still set from above
        mode = C_MODEL; busy_len = 20; p0 = pulses;
        wr(8'h61);
        wr(8'h62);
        wr(8'h63);
        step(3);
        chk("t6_count_pre", count, 2);
        chk("t6_ovf_pre", overflow, 1);
        reset = 1'b1;
        #1;
        chk("t6_txen", tx_enable, 0);
        chk("t6_empty", empty, 1);
        chk("t6_count", count, 0);
        chk("t6_ovf", overflow, 0);
        step();
        reset = 1'b0;
        step(30);
        chk("t6_pulses", pulses - p0, 1);
        chk("t6_empty_end", empty, 1);

        // tx_enable drops asynchronously during LAUNCH
        mode = C_IGNORE;
        wr(8'h77);
        step();
        chk("t7_txen", tx_enable, 1);
        reset = 1'b1;
        #1;
        chk("t7_txen_async", tx_enable, 0);
        step();
        reset = 1'b0;
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
